// File: rtl/rx_pkt_buffer_ctrl.sv
// rx_pkt_buffer_ctrl
//   Packet-level address controller for a byte-wide packet RAM shared by one
//   producer (RX side) and one consumer. Bytes are written speculatively; the
//   write pointer is committed (its last-byte address pushed into a small
//   end-pointer FIFO) only at end-of-packet. Abort, restart and overflow roll
//   the write pointer back to the packet start, so the consumer only ever sees
//   whole, good packets.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   wr_sop/valid/eop/abort  producer byte qualifiers (sop/eop qualified by valid)
//   wr_ready        controller can accept a byte this cycle
//   mem_wr_en       RAM write strobe (combinational, accepted byte)
//   mem_wr_addr     RAM write address
//   pkt_drop        one-cycle pulse in the cycle a packet is discarded
//   rd_req          consumer takes the byte at mem_rd_addr
//   rd_pkt_avail    at least one committed, unread packet
//   rd_last         mem_rd_addr holds the last byte of the current packet
//   mem_rd_addr     RAM read address
//
// state | meaning
// IDLE  | between packets, waiting for a sop byte
// WRITE | packet in progress, bytes written from start_ptr onward
// DROP  | packet discarded, swallowing bytes until eop or abort
module rx_pkt_buffer_ctrl #(
  parameter int ADDR_BITS = 6,
  parameter int PKT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_sop,
  input  logic                 wr_valid,
  input  logic                 wr_eop,
  input  logic                 wr_abort,
  output logic                 wr_ready,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic                 pkt_drop,
  input  logic                 rd_req,
  output logic                 rd_pkt_avail,
  output logic                 rd_last,
  output logic [ADDR_BITS-1:0] mem_rd_addr
);

  localparam int IDX_BITS = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(PKT_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_BITS-1:0] start_ptr, start_ptr_nxt;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] push_val;
  logic [ADDR_BITS-1:0] used;
  logic [ADDR_BITS-1:0] end_fifo [PKT_DEPTH];
  logic [IDX_BITS-1:0]  head, tail;
  logic [CNT_BITS-1:0]  count;
  logic                 full, push, pop, push_ok, rd_take;

  function automatic logic [IDX_BITS-1:0] idx_inc(input logic [IDX_BITS-1:0] i);
    return (i == IDX_BITS'(PKT_DEPTH - 1)) ? '0 : i + IDX_BITS'(1);
  endfunction

  // One slot is kept empty so that wr_ptr == rd_ptr always means empty.
  assign used         = wr_ptr - rd_ptr;
  assign full         = (used == {ADDR_BITS{1'b1}});
  assign rd_pkt_avail = (count != '0);
  assign rd_last      = rd_pkt_avail && (rd_ptr == end_fifo[head]);
  assign rd_take      = rd_req && rd_pkt_avail;
  assign pop          = rd_take && rd_last;
  // A same-cycle pop makes room for the commit being checked.
  assign push_ok      = (count != CNT_BITS'(PKT_DEPTH)) || pop;
  assign wr_ready     = (state != DROP) && !full;
  assign mem_wr_addr  = wr_addr;
  assign mem_rd_addr  = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      rd_ptr    <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < PKT_DEPTH; i++) end_fifo[i] <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      start_ptr <= start_ptr_nxt;
      if (rd_take) rd_ptr <= rd_ptr + ADDR_BITS'(1);
      if (push) begin
        end_fifo[tail] <= push_val;
        tail           <= idx_inc(tail);
      end
      if (pop) head <= idx_inc(head);
      if (push && !pop)      count <= count + CNT_BITS'(1);
      else if (pop && !push) count <= count - CNT_BITS'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    start_ptr_nxt = start_ptr;
    wr_addr       = wr_ptr;
    push_val      = wr_ptr;
    mem_wr_en     = 1'b0;
    pkt_drop      = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (wr_valid && wr_sop) begin
          start_ptr_nxt = wr_ptr;
          if (full) begin
            pkt_drop = 1'b1;
            if (!wr_eop) state_nxt = DROP;
          end else if (wr_eop && !push_ok) begin
            pkt_drop = 1'b1;
          end else begin
            mem_wr_en  = 1'b1;
            wr_ptr_nxt = wr_ptr + ADDR_BITS'(1);
            if (wr_eop) push = 1'b1;
            else        state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        if (wr_abort) begin
          wr_ptr_nxt = start_ptr;
          pkt_drop   = 1'b1;
          state_nxt  = IDLE;
        end else if (wr_valid && wr_sop) begin
          // Restart: the old packet is dropped and the new one reuses its
          // start address in the same cycle. Space below start_ptr is never
          // full while a packet is in progress, so only the commit can fail.
          pkt_drop = 1'b1;
          wr_addr  = start_ptr;
          if (wr_eop && !push_ok) begin
            wr_ptr_nxt = start_ptr;
            state_nxt  = IDLE;
          end else begin
            mem_wr_en  = 1'b1;
            wr_ptr_nxt = start_ptr + ADDR_BITS'(1);
            push_val   = start_ptr;
            push       = wr_eop;
            state_nxt  = wr_eop ? IDLE : WRITE;
          end
        end else if (wr_valid) begin
          if (full || (wr_eop && !push_ok)) begin
            wr_ptr_nxt = start_ptr;
            pkt_drop   = 1'b1;
            state_nxt  = wr_eop ? IDLE : DROP;
          end else begin
            mem_wr_en  = 1'b1;
            wr_ptr_nxt = wr_ptr + ADDR_BITS'(1);
            if (wr_eop) begin
              push      = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (wr_abort || (wr_valid && wr_eop)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_pkt_buffer_ctrl.sv
module tb_rx_pkt_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_sop = 1'b0, wr_valid = 1'b0, wr_eop = 1'b0, wr_abort = 1'b0, rd_req = 1'b0;
  logic       wr_ready, mem_wr_en, pkt_drop, rd_pkt_avail, rd_last;
  logic [3:0] mem_wr_addr, mem_rd_addr;

  rx_pkt_buffer_ctrl #(.ADDR_BITS(4), .PKT_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_sop(wr_sop), .wr_valid(wr_valid), .wr_eop(wr_eop), .wr_abort(wr_abort),
    .wr_ready(wr_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .pkt_drop(pkt_drop), .rd_req(rd_req), .rd_pkt_avail(rd_pkt_avail),
    .rd_last(rd_last), .mem_rd_addr(mem_rd_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // sampled DUT outputs
  logic       s_ready, s_en, s_drop, s_avail, s_last;
  logic [3:0] s_waddr, s_raddr;
  // reference model expectations
  logic       e_ready, e_en, e_drop, e_avail, e_last;
  logic [3:0] e_waddr, e_raddr;
  // reference model state: mode 0 = between packets, 1 = in packet, 2 = discarding
  int m_wp, m_sp, m_rp, m_mode;
  int m_ends[$];

  task automatic model_cycle(input logic sop, valid, eop, abort, rdreq);
    bit pop, room;
    e_ready = (m_mode != 2) && (((m_wp - m_rp) & 15) != 15);
    e_avail = (m_ends.size() > 0);
    e_last  = 1'b0;
    if (e_avail) e_last = (m_rp == m_ends[0]);
    e_raddr = m_rp[3:0];
    e_waddr = m_wp[3:0];
    e_en    = 1'b0;
    e_drop  = 1'b0;
    pop  = rdreq && e_last;
    room = (m_ends.size() < 4) || pop;
    if (m_mode == 1 && abort) begin
      e_drop = 1'b1; m_wp = m_sp; m_mode = 0;
    end else if (valid && m_mode != 2 && (sop || m_mode == 1)) begin
      if (sop) begin
        if (m_mode == 1) begin e_drop = 1'b1; m_wp = m_sp; end
        else m_sp = m_wp;
      end
      e_waddr = m_wp[3:0];
      if (((m_wp - m_rp) & 15) == 15 || (eop && !room)) begin
        e_drop = 1'b1; m_wp = m_sp; m_mode = eop ? 0 : 2;
      end else begin
        e_en = 1'b1;
        if (eop) begin m_ends.push_back(m_wp); m_mode = 0; end
        else m_mode = 1;
        m_wp = (m_wp + 1) & 15;
      end
    end else if (m_mode == 2 && (abort || (valid && eop))) begin
      m_mode = 0;
    end
    if (rdreq && e_avail) begin
      m_rp = (m_rp + 1) & 15;
      if (pop) void'(m_ends.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_sop = 0; wr_valid = 0; wr_eop = 0; wr_abort = 0; rd_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_wp = 0; m_sp = 0; m_rp = 0; m_mode = 0;
    m_ends.delete();
  endtask

  task automatic drive(input logic sop, valid, eop, abort, rdreq);
    wr_sop = sop; wr_valid = valid; wr_eop = eop; wr_abort = abort; rd_req = rdreq;
    model_cycle(sop, valid, eop, abort, rdreq);
    @(negedge clk);
    s_ready = wr_ready; s_en = mem_wr_en; s_drop = pkt_drop; s_avail = rd_pkt_avail;
    s_last = rd_last; s_waddr = mem_wr_addr; s_raddr = mem_rd_addr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    n_checks++; if ({s_ready, s_en, s_drop, s_avail, s_last, s_waddr, s_raddr} !== 13'b1_0000_0000_0000)
      $display("FAIL reset_outputs got %b want 1000000000000", {s_ready, s_en, s_drop, s_avail, s_last, s_waddr, s_raddr}); else n_pass++;
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_checks++; if (s_avail !== 1'b1) $display("FAIL pre_reset_avail got %b want 1", s_avail); else n_pass++;
    do_reset();
    drive(0, 1, 0, 0, 0);
    n_checks++; if ({s_waddr, s_raddr} !== 8'h00) $display("FAIL midreset_addrs got %h want 00", {s_waddr, s_raddr}); else n_pass++;
    n_checks++; if ({s_avail, s_ready, s_en, s_drop} !== 4'b0100) $display("FAIL midreset_flags got %b want 0100", {s_avail, s_ready, s_en, s_drop}); else n_pass++;
  endtask

  task automatic test_basic_packet();
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1, i == 2, 0, 0);
      n_checks++; if ({s_en, s_waddr} !== {1'b1, 4'(i)}) $display("FAIL basic_wr_%0d got %b want 1_%b", i, {s_en, s_waddr}, 4'(i)); else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    n_checks++; if ({s_avail, s_last} !== 2'b10) $display("FAIL basic_avail got %b want 10", {s_avail, s_last}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++; if ({s_raddr, s_last} !== {4'(i), i == 2}) $display("FAIL basic_rd_%0d got %b want %b_%b", i, {s_raddr, s_last}, 4'(i), i == 2); else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    n_checks++; if ({s_avail, s_raddr} !== 5'b0_0011) $display("FAIL basic_drained got %b want 00011", {s_avail, s_raddr}); else n_pass++;
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 1, 0, 0, 0);
      n_checks++; if (s_waddr !== 4'(3 + i)) $display("FAIL abort_wr_%0d got %0d want %0d", i, s_waddr, 3 + i); else n_pass++;
    end
    drive(0, 0, 0, 1, 0);
    n_checks++; if ({s_drop, s_en} !== 2'b10) $display("FAIL abort_drop got %b want 10", {s_drop, s_en}); else n_pass++;
    drive(0, 0, 0, 0, 0);
    n_checks++; if ({s_drop, s_waddr} !== 5'b0_0011) $display("FAIL abort_rollback got %b want 00011", {s_drop, s_waddr}); else n_pass++;
    drive(1, 1, 1, 0, 0);
    n_checks++; if ({s_en, s_waddr} !== 5'b1_0011) $display("FAIL abort_next_sop got %b want 10011", {s_en, s_waddr}); else n_pass++;
    drive(0, 0, 0, 0, 1);
    n_checks++; if ({s_last, s_raddr} !== 5'b1_0011) $display("FAIL abort_next_rd got %b want 10011", {s_last, s_raddr}); else n_pass++;
  endtask

  task automatic test_overflow_bytes();
    do_reset();
    for (int i = 0; i < 15; i++) drive(i == 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_checks++; if ({s_ready, s_en, s_drop} !== 3'b001) $display("FAIL ovf_16th got %b want 001", {s_ready, s_en, s_drop}); else n_pass++;
    drive(0, 1, 0, 0, 0);
    n_checks++; if ({s_ready, s_en, s_drop, s_waddr} !== 7'b000_0000) $display("FAIL ovf_drop_state got %b want 0000000", {s_ready, s_en, s_drop, s_waddr}); else n_pass++;
    drive(0, 1, 1, 0, 0);
    n_checks++; if ({s_en, s_drop} !== 2'b00) $display("FAIL ovf_eop got %b want 00", {s_en, s_drop}); else n_pass++;
    drive(0, 0, 0, 0, 0);
    n_checks++; if ({s_ready, s_avail, s_waddr} !== 6'b10_0000) $display("FAIL ovf_recover got %b want 100000", {s_ready, s_avail, s_waddr}); else n_pass++;
  endtask

  task automatic test_end_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    n_checks++; if ({s_en, s_drop} !== 2'b01) $display("FAIL fifo_full_drop got %b want 01", {s_en, s_drop}); else n_pass++;
    drive(0, 0, 0, 0, 0);
    n_checks++; if ({s_avail, s_waddr} !== 5'b1_0100) $display("FAIL fifo_full_wp got %b want 10100", {s_avail, s_waddr}); else n_pass++;
    drive(1, 1, 1, 0, 1);
    n_checks++; if ({s_en, s_drop, s_waddr, s_last} !== 7'b10_0100_1) $display("FAIL fifo_pop_push got %b want 1001001", {s_en, s_drop, s_waddr, s_last}); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++; if ({s_avail, s_last, s_raddr} !== {2'b11, 4'(i)}) $display("FAIL fifo_rd_%0d got %b want 11%b", i, {s_avail, s_last, s_raddr}, 4'(i)); else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    n_checks++; if (s_avail !== 1'b0) $display("FAIL fifo_drained got %b want 0", s_avail); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 14; i++) drive(i == 0, 1, i == 13, 0, 0);
    for (int i = 0; i < 14; i++) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1, i == 3, 0, 0);
      n_checks++; if ({s_en, s_waddr} !== {1'b1, 4'((14 + i) % 16)}) $display("FAIL wrap_wr_%0d got %b want 1_%b", i, {s_en, s_waddr}, 4'((14 + i) % 16)); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++; if ({s_raddr, s_last} !== {4'((14 + i) % 16), i == 3}) $display("FAIL wrap_rd_%0d got %b want %b_%b", i, {s_raddr, s_last}, 4'((14 + i) % 16), i == 3); else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    n_checks++; if (s_avail !== 1'b0) $display("FAIL wrap_drained got %b want 0", s_avail); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    n_checks++; if ({s_drop, s_en, s_waddr} !== 6'b11_0000) $display("FAIL b2b_restart got %b want 110000", {s_drop, s_en, s_waddr}); else n_pass++;
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    n_checks++; if ({s_en, s_waddr} !== 5'b1_0010) $display("FAIL b2b_eop got %b want 10010", {s_en, s_waddr}); else n_pass++;
    drive(1, 1, 1, 0, 0);
    n_checks++; if ({s_en, s_waddr, s_avail} !== 6'b1_0011_1) $display("FAIL b2b_next got %b want 100111", {s_en, s_waddr, s_avail}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++; if ({s_raddr, s_last} !== {4'(i), i >= 2}) $display("FAIL b2b_rd_%0d got %b want %b_%b", i, {s_raddr, s_last}, 4'(i), i >= 2); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic sop, valid, eop, abort, rdreq;
    int rd_pct;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rd_pct = ((cyc % 600) < 300) ? 15 : 70;
      valid  = ($urandom_range(0, 99) < 70);
      sop    = ($urandom_range(0, 99) < 15);
      eop    = ($urandom_range(0, 99) < 15);
      abort  = ($urandom_range(0, 99) < 3);
      rdreq  = ($urandom_range(0, 99) < rd_pct);
      drive(sop, valid, eop, abort, rdreq);
      n_checks++;
      if ({s_ready, s_en, s_drop, s_avail, s_last, s_waddr, s_raddr} !== {e_ready, e_en, e_drop, e_avail, e_last, e_waddr, e_raddr})
        $display("FAIL random_cyc%0d rdy/en/drop/avail/last/wa/ra got %b want %b", cyc,
                 {s_ready, s_en, s_drop, s_avail, s_last, s_waddr, s_raddr},
                 {e_ready, e_en, e_drop, e_avail, e_last, e_waddr, e_raddr});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_abort();
    test_overflow_bytes();
    test_end_fifo_full();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
